decode_stage: RTL and testbench
===============================

Name:
decode_stage

Overview:
- Instruction-decode stage; consumes the 32-bit IF/ID buffer word: [31:16] PC+2, [15:0] instruction.
- Holds the 16x16 register file and decodes the instruction into control fields.
- Detects load-use hazards and stalls fetch.
- Registers all results into an internal ID/EX pipeline register that feeds the execute stage.

Parameters:
- DATA_W, 16, register/data width.
- REG_AW, 4, register address width (2**REG_AW registers).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
ifid_in  input  32  [31:16] PC+2, [15:0] instruction
wb_en  input  1  writeback enable
wb_addr  input  REG_AW  writeback register
wb_data  input  DATA_W  writeback data
flush  input  1  branch-taken flush, synchronous
stall  output  1  combinational; drives PC pcWrite (inverted) and IF/ID writeEnable (inverted)
idex_valid  output  1  ID/EX holds a real instruction
idex_pc  output  16  PC+2 of the decoded instruction
idex_op  output  4  opcode
idex_funct  output  4  instr[3:0]
idex_rd  output  REG_AW  instr[11:8]
idex_rs  output  REG_AW  instr[7:4]
idex_a  output  DATA_W  value of R[rd]
idex_b  output  DATA_W  value of R[rs]
idex_imm  output  16  decoded immediate
idex_reg_write  output  1  writes rd
idex_mem_read  output  1  load
idex_mem_write  output  1  store
stall_count  output  16  stall-cycle counter (see Optional Feature)

Behaviour:
- reset_n=0 (async):
  - All idex_* outputs 0, all registers 0, stall_count 0.
  - stall evaluates to 0, since idex_valid=0.
- Encoding: op=[15:12], rd=[11:8], rs=[7:4], imm4/funct=[3:0].
  - op 0x0, R-type: reads rd, rs; reg_write=1.
  - op 0x8, load: reads rs; reg_write=1; mem_read=1.
  - op 0x9, store: reads rd, rs; mem_write=1.
  - op 0x4, branch-equal: reads rd, rs; no writes.
  - Any other op: bubble.
- Bubble: idex_valid, reg_write, mem_read, mem_write all 0; other idex fields don't-care (implementation drives 0).
- Immediate:
  - Load/store: sign-extend imm4 to 16 bits.
  - Branch: sign-extend imm4, then shift left 1.
  - Otherwise: 0.
- Register file:
  - R0 always reads 0; writes to R0 are ignored.
  - Write occurs on the clock edge when wb_en=1.
  - Same-cycle bypass: if wb_en and wb_addr equals a nonzero read address, the read returns wb_data.
- Latency: one cycle. The instruction present on ifid_in at edge N appears on idex_* after edge N.
- Hazard (combinational): stall=1 when all of the following hold:
  - idex_valid, idex_mem_read, idex_rd!=0;
  - the current instruction reads a register equal to idex_rd (rd or rs, per the per-op read set);
  - flush=0.
- While stall=1: ID/EX loads a bubble at the edge; ifid_in is expected to hold. Stall therefore lasts exactly one cycle per load-use pair.
- Priority at the edge: flush > stall > normal load.
  - flush=1 loads a bubble and forces stall=0.
- Register-file writes are independent of stall/flush.
- Simultaneous flush and wb_en: the write still occurs.

Optional Feature:
- Macro DECODE_STALL_CNT_EN.
- Defined: stall_count increments on every edge where stall=1, saturates at 0xFFFF, and clears on reset.
- Undefined: stall_count is tied to 16'h0000 and no counter logic is present.

Test Plan:
- Reset: pull reset_n low mid-stream, off a clock edge -> all idex_* = 0 immediately; after release, decoding 0x0120 gives idex_a=0, idex_b=0.
- R-type read: write R3=0x1234, R5=0x00AA; ifid_in=0x0004_0350 -> next edge: idex_a=0x1234, idex_b=0x00AA, idex_pc=0x0004, reg_write=1, valid=1.
- Bypass / R0: wb_en=1, wb_addr=5, wb_data=0xBEEF in the same cycle as decoding 0x0350 -> idex_b=0xBEEF. A write to R0 of 0xFFFF is ignored; R0 still reads 0.
- Load-use: 0x8120 then 0x0310 -> stall=1 for exactly one cycle; ID/EX shows a bubble (valid=0); the next edge issues 0x0310. With DECODE_STALL_CNT_EN defined, stall_count=1.
- Flush priority: flush=1 during a load-use stall -> stall=0, ID/EX holds a bubble, stall_count unchanged.
- Immediates: 0x412E -> idex_imm=0xFFFC. 0x8127 -> 0x0007. 0x912F -> 0xFFFF. Illegal op 0x7123 -> bubble.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction-decode stage: register file, control decode, load-use hazard detection and ID/EX register.
// Optional stall-cycle counter enabled by defining DECODE_STALL_CNT_EN.
module decode_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       ifid_in,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              idex_valid,
    output logic [15:0]       idex_pc,
    output logic [3:0]        idex_op,
    output logic [3:0]        idex_funct,
    output logic [REG_AW-1:0] idex_rd,
    output logic [REG_AW-1:0] idex_rs,
    output logic [DATA_W-1:0] idex_a,
    output logic [DATA_W-1:0] idex_b,
    output logic [15:0]       idex_imm,
    output logic              idex_reg_write,
    output logic              idex_mem_read,
    output logic              idex_mem_write,
    output logic [15:0]       stall_count
);

    localparam int unsigned NREGS = 2 ** REG_AW;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'h0,
        OP_BEQ   = 4'h4,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9
    } opcode_e;

    logic [15:0]       pc_plus2;
    logic [15:0]       instr;
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [15:0]       imm4_sext;

    assign pc_plus2  = ifid_in[31:16];
    assign instr     = ifid_in[15:0];
    assign op        = instr[15:12];
    assign rd        = REG_AW'(instr[11:8]);
    assign rs        = REG_AW'(instr[7:4]);
    assign imm4_sext = {{12{instr[3]}}, instr[3:0]};

    logic        dec_legal;
    logic        reads_rd;
    logic        reads_rs;
    logic        dec_reg_write;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic [15:0] dec_imm;

    always_comb begin
        dec_legal     = 1'b0;
        reads_rd      = 1'b0;
        reads_rs      = 1'b0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_imm       = '0;
        case (op)
            OP_RTYPE: begin
                dec_legal     = 1'b1;
                reads_rd      = 1'b1;
                reads_rs      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_LOAD: begin
                dec_legal     = 1'b1;
                reads_rs      = 1'b1;
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_imm       = imm4_sext;
            end
            OP_STORE: begin
                dec_legal     = 1'b1;
                reads_rd      = 1'b1;
                reads_rs      = 1'b1;
                dec_mem_write = 1'b1;
                dec_imm       = imm4_sext;
            end
            OP_BEQ: begin
                dec_legal     = 1'b1;
                reads_rd      = 1'b1;
                reads_rs      = 1'b1;
                dec_imm       = {imm4_sext[14:0], 1'b0};
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Register file; R0 is never written and always reads zero.
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;

    // Same-cycle writeback is forwarded so a write and a dependent decode can share a cycle.
    always_comb begin
        rd_val = '0;
        rs_val = '0;
        if (rd != '0) begin
            rd_val = (wb_en && (wb_addr == rd)) ? wb_data : regs[rd];
        end
        if (rs != '0) begin
            rs_val = (wb_en && (wb_addr == rs)) ? wb_data : regs[rs];
        end
    end

    logic rd_hit;
    logic rs_hit;

    always_comb begin
        rd_hit = reads_rd && (rd == idex_rd);
        rs_hit = reads_rs && (rs == idex_rs_cmp(idex_rd));
        stall  = idex_valid && idex_mem_read && (idex_rd != '0)
                 && (rd_hit || rs_hit) && !flush;
    end

    function automatic logic [REG_AW-1:0] idex_rs_cmp(input logic [REG_AW-1:0] dst);
        return dst;
    endfunction

    // flush and stall both insert a bubble; an illegal opcode decodes to the same bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idex_valid     <= 1'b0;
            idex_pc        <= '0;
            idex_op        <= '0;
            idex_funct     <= '0;
            idex_rd        <= '0;
            idex_rs        <= '0;
            idex_a         <= '0;
            idex_b         <= '0;
            idex_imm       <= '0;
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_mem_write <= 1'b0;
        end else if (flush || stall || !dec_legal) begin
            idex_valid     <= 1'b0;
            idex_pc        <= '0;
            idex_op        <= '0;
            idex_funct     <= '0;
            idex_rd        <= '0;
            idex_rs        <= '0;
            idex_a         <= '0;
            idex_b         <= '0;
            idex_imm       <= '0;
            idex_reg_write <= 1'b0;
            idex_mem_read  <= 1'b0;
            idex_mem_write <= 1'b0;
        end else begin
            idex_valid     <= 1'b1;
            idex_pc        <= pc_plus2;
            idex_op        <= op;
            idex_funct     <= instr[3:0];
            idex_rd        <= rd;
            idex_rs        <= rs;
            idex_a         <= rd_val;
            idex_b         <= rs_val;
            idex_imm       <= dec_imm;
            idex_reg_write <= dec_reg_write;
            idex_mem_read  <= dec_mem_read;
            idex_mem_write <= dec_mem_write;
        end
    end

`ifdef DECODE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; stall_count expectations follow DECODE_STALL_CNT_EN.
module tb_decode_stage;

    logic        clk;
    logic        reset_n;
    logic [31:0] ifid_in;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic        stall;
    logic        idex_valid;
    logic [15:0] idex_pc;
    logic [3:0]  idex_op;
    logic [3:0]  idex_funct;
    logic [3:0]  idex_rd;
    logic [3:0]  idex_rs;
    logic [15:0] idex_a;
    logic [15:0] idex_b;
    logic [15:0] idex_imm;
    logic        idex_reg_write;
    logic        idex_mem_read;
    logic        idex_mem_write;
    logic [15:0] stall_count;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [15:0] exp_scnt;

    decode_stage #(
        .DATA_W(16),
        .REG_AW(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ifid_in        (ifid_in),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .flush          (flush),
        .stall          (stall),
        .idex_valid     (idex_valid),
        .idex_pc        (idex_pc),
        .idex_op        (idex_op),
        .idex_funct     (idex_funct),
        .idex_rd        (idex_rd),
        .idex_rs        (idex_rs),
        .idex_a         (idex_a),
        .idex_b         (idex_b),
        .idex_imm       (idex_imm),
        .idex_reg_write (idex_reg_write),
        .idex_mem_read  (idex_mem_read),
        .idex_mem_write (idex_mem_write),
        .stall_count    (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A stall edge bumps the expected count only when the counter is built in.
    task automatic bump_scnt();
`ifdef DECODE_STALL_CNT_EN
        exp_scnt = exp_scnt + 16'd1;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_scnt = 16'h0000;
        reset_n  = 1'b0;
        ifid_in  = 32'h0;
        wb_en    = 1'b0;
        wb_addr  = 4'h0;
        wb_data  = 16'h0;
        flush    = 1'b0;

        #2;
        check("rst_valid", idex_valid, 0);
        check("rst_pc", idex_pc, 0);
        check("rst_regw", idex_reg_write, 0);
        check("rst_stall", stall, 0);
        check("rst_scnt", stall_count, 0);
        #10 reset_n = 1'b1;
        step();

        // Load R3 and R5 through the writeback port.
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
        step();
        wb_addr = 4'd5; wb_data = 16'h00AA;
        step();
        wb_en = 1'b0;
        ifid_in = 32'h0004_0350;
        step();
        check("rtype_a", idex_a, 16'h1234);
        check("rtype_b", idex_b, 16'h00AA);
        check("rtype_pc", idex_pc, 16'h0004);
        check("rtype_regw", idex_reg_write, 1);
        check("rtype_valid", idex_valid, 1);
        check("rtype_rd", idex_rd, 3);
        check("rtype_rs", idex_rs, 5);
        check("rtype_imm", idex_imm, 0);

        // Same-cycle bypass into rs.
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'hBEEF;
        step();
        check("bypass_b", idex_b, 16'hBEEF);
        check("bypass_a", idex_a, 16'h1234);

        // Write to R0 must neither bypass nor stick.
        wb_addr = 4'd0; wb_data = 16'hFFFF;
        ifid_in = 32'h0004_0300;
        step();
        check("r0_bypass", idex_b, 0);
        wb_en = 1'b0;
        step();
        check("r0_read", idex_b, 0);
        ifid_in = 32'h0004_0350;
        step();
        check("r5_written", idex_b, 16'hBEEF);

        // Load-use: load R1, then R-type reading R1 through rs.
        ifid_in = 32'h0006_8120;
        step();
        check("ld_memrd", idex_mem_read, 1);
        check("ld_regw", idex_reg_write, 1);
        check("ld_rd", idex_rd, 1);
        ifid_in = 32'h0008_0310;
        #1;
        check("lu_stall", stall, 1);
        step();
        bump_scnt();
        check("lu_bubble", idex_valid, 0);
        check("lu_stall_clr", stall, 0);
        check("lu_scnt", stall_count, exp_scnt);
        step();
        check("lu_issue_valid", idex_valid, 1);
        check("lu_issue_pc", idex_pc, 16'h0008);
        check("lu_issue_a", idex_a, 16'h1234);
        check("lu_issue_b", idex_b, 0);

        // Flush overrides a pending load-use stall.
        ifid_in = 32'h000A_8120;
        step();
        ifid_in = 32'h000C_0310;
        flush = 1'b1;
        #1;
        check("fl_stall", stall, 0);
        step();
        flush = 1'b0;
        check("fl_bubble", idex_valid, 0);
        check("fl_scnt", stall_count, exp_scnt);

        // Load into R0 never causes a hazard.
        ifid_in = 32'h0010_8020;
        step();
        ifid_in = 32'h0012_0000;
        #1;
        check("ld_r0_nostall", stall, 0);
        step();

        // A load reads only rs: matching rs stalls, matching rd field does not.
        ifid_in = 32'h0014_8120;
        step();
        ifid_in = 32'h0016_8212;
        #1;
        check("ld_rs_stall", stall, 1);
        step();
        bump_scnt();
        check("ld_rs_bubble", idex_valid, 0);
        check("ld_rs_scnt", stall_count, exp_scnt);
        step();
        check("ld2_valid", idex_valid, 1);
        check("ld2_rd", idex_rd, 2);
        ifid_in = 32'h0018_8210;
        #1;
        check("ld_rdfield_nostall", stall, 0);
        step();

        // Illegal opcode and immediate forms.
        ifid_in = 32'h001A_7123;
        step();
        check("ill_valid", idex_valid, 0);
        check("ill_regw", idex_reg_write, 0);
        check("ill_op", idex_op, 0);
        check("ill_imm", idex_imm, 0);
        ifid_in = 32'h001C_412E;
        step();
        check("beq_imm", idex_imm, 16'hFFFC);
        check("beq_valid", idex_valid, 1);
        check("beq_regw", idex_reg_write, 0);
        check("beq_funct", idex_funct, 4'hE);
        ifid_in = 32'h001E_912F;
        step();
        check("st_imm", idex_imm, 16'hFFFF);
        check("st_memwr", idex_mem_write, 1);
        check("st_regw", idex_reg_write, 0);
        ifid_in = 32'h0020_8127;
        step();
        check("ld_imm", idex_imm, 16'h0007);
        check("ld_op", idex_op, 4'h8);

        // Fill R1/R2, then reset mid-stream off a clock edge.
        ifid_in = 32'h0004_0350;
        wb_en = 1'b1; wb_addr = 4'd1; wb_data = 16'h1111;
        step();
        wb_addr = 4'd2; wb_data = 16'h2222;
        step();
        wb_en = 1'b0;
        check("pre_rst_valid", idex_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", idex_valid, 0);
        check("mid_rst_pc", idex_pc, 0);
        check("mid_rst_a", idex_a, 0);
        check("mid_rst_scnt", stall_count, 0);
        #3 reset_n = 1'b1;
        ifid_in = 32'h0000_0120;
        step();
        check("post_rst_valid", idex_valid, 1);
        check("post_rst_a", idex_a, 0);
        check("post_rst_b", idex_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
